// File: rtl/rv_rf_wport_ctrl.sv
// rv_rf_wport_ctrl
// Arbitrates the single register-file write port between the in-order
// pipeline writeback (W stage) and results returning from multicycle units
// (divider, loads). A returning result is parked in a one-entry holding
// register H. H gets the port whenever the pipeline is not writing. If the
// pipeline keeps winning, a starvation counter eventually stalls W so that
// H can drain.
// A pending scoreboard tracks registers whose multicycle result has not yet
// reached the register file. Decode stalls on any source or destination
// that is still pending.

module rv_rf_wport_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // pipeline writeback
  input  logic        w_valid_i,
  input  logic [4:0]  w_rd_i,
  input  logic [31:0] w_value_i,
  output logic        w_stall_o,
  // multicycle issue and result
  input  logic        m_issue_i,
  input  logic [4:0]  m_issue_rd_i,
  input  logic        m_valid_i,
  input  logic [4:0]  m_rd_i,
  input  logic [31:0] m_value_i,
  output logic        m_ready_o,
  // decode hazard check
  input  logic        d_valid_i,
  input  logic [4:0]  d_rs1_i,
  input  logic [4:0]  d_rs2_i,
  input  logic [4:0]  d_rd_i,
  output logic        d_stall_o,
  // register file write port
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_value_o,
  output logic        rf_store_o,
  output logic        busy_o
);

  // The counter is 4 bits wide, so the limit can be at most 15.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Owner of the write port in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_HOLD
  } grant_e;

  // Holding register for a returned multicycle result.
  logic        hv;
  logic [4:0]  hrd;
  logic [31:0] hval;

  // One bit per architectural register whose multicycle write is outstanding.
  logic [31:0] pending;

  // Counts consecutive cycles in which H lost the port to the pipeline.
  logic [3:0]  starve_cnt;

  grant_e      grant;
  logic        stall;
  logic        accept;
  logic        drain;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_next;
  logic [3:0]  starve_next;
  logic        hit_rs1;
  logic        hit_rs2;
  logic        hit_rd;

  // Decide which source owns the write port; stall W once H has starved long enough.
  always_comb begin
    stall = rst_n_i && hv && (starve_cnt == LIMIT);
    grant = GRANT_NONE;
    if (w_valid_i && !stall) begin
      grant = GRANT_PIPE;
    end else if (hv) begin
      grant = GRANT_HOLD;
    end
    drain  = (grant == GRANT_HOLD);
    accept = m_valid_i && !hv;
  end

  // Drive the register-file port from the granted source (H fields when idle).
  always_comb begin
    rf_rd_o    = hrd;
    rf_value_o = hval;
    if (grant == GRANT_PIPE) begin
      rf_rd_o    = w_rd_i;
      rf_value_o = w_value_i;
    end
    // A grant to x0 still consumes the request but never writes.
    rf_store_o = rst_n_i && (grant != GRANT_NONE) && (rf_rd_o != 5'd0);
    w_stall_o  = stall;
    m_ready_o  = !hv;
  end

  // Decode hazard check against the registered scoreboard; x0 never hazards.
  always_comb begin
    hit_rs1   = (d_rs1_i != 5'd0) && pending[d_rs1_i];
    hit_rs2   = (d_rs2_i != 5'd0) && pending[d_rs2_i];
    hit_rd    = (d_rd_i  != 5'd0) && pending[d_rd_i];
    d_stall_o = rst_n_i && d_valid_i && (hit_rs1 || hit_rs2 || hit_rd);
    busy_o    = hv || (|pending);
  end

  // Scoreboard next value: a new issue to the same register beats the drain clear.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (drain && (hrd != 5'd0)) begin
      clr_mask = 32'd1 << hrd;
    end
    if (m_issue_i && (m_issue_rd_i != 5'd0)) begin
      set_mask = 32'd1 << m_issue_rd_i;
    end
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  // Starvation counter next value: counts pipeline wins while H waits, saturates at the limit.
  always_comb begin
    starve_next = starve_cnt;
    if (!hv || drain) begin
      starve_next = 4'd0;
    end else if ((grant == GRANT_PIPE) && (starve_cnt != LIMIT)) begin
      starve_next = starve_cnt + 4'd1;
    end
  end

  // State register: holding entry, scoreboard and starvation counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hv         <= 1'b0;
      hrd        <= 5'd0;
      hval       <= 32'd0;
      pending    <= '0;
      starve_cnt <= 4'd0;
    end else begin
      // Accept only happens with H empty and drain only with H full, so the two never collide.
      if (accept) begin
        hv   <= 1'b1;
        hrd  <= m_rd_i;
        hval <= m_value_i;
      end else if (drain) begin
        hv   <= 1'b0;
      end
      pending    <= pending_next;
      starve_cnt <= starve_next;
    end
  end

endmodule

// File: doc/rv_rf_wport_ctrl.md
RV_RF_WPORT_CTRL -- requirements
Module: rv_rf_wport_ctrl

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive cycles a held multicycle result may lose arbitration (legal range 1..15).
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 w_valid_i  in  1  pipeline writeback request (W stage).
REQ-005 w_rd_i  in  5  pipeline writeback destination register.
REQ-006 w_value_i  in  32  pipeline writeback data.
REQ-007 w_stall_o  out  1  stall W stage; pipeline holds its writeback.
REQ-008 m_issue_i  in  1  multicycle op (div/load) issued this cycle.
REQ-009 m_issue_rd_i  in  5  destination register of the issued multicycle op.
REQ-010 m_valid_i  in  1  multicycle result valid.
REQ-011 m_rd_i  in  5  multicycle result destination register.
REQ-012 m_value_i  in  32  multicycle result data.
REQ-013 m_ready_o  out  1  controller accepts the multicycle result.
REQ-014 d_valid_i  in  1  decode holds a valid instruction.
REQ-015 d_rs1_i, d_rs2_i, d_rd_i  in  5 each  decode source/destination registers.
REQ-016 d_stall_o  out  1  decode hazard stall.
REQ-017 rf_rd_o  out  5  register file write address.
REQ-018 rf_value_o  out  32  register file write data.
REQ-019 rf_store_o  out  1  register file write enable.
REQ-020 busy_o  out  1  any multicycle result pending or held.

Function
REQ-021 State SHALL be: holding register H (hv, hrd[4:0], hval[31:0]); pending[31:0] scoreboard; starve_cnt (4 bits).
REQ-022 m_ready_o SHALL equal !hv; result accepted (m_valid_i && m_ready_o) SHALL load H, hv=1 next cycle.
REQ-023 w_stall_o SHALL equal hv && (starve_cnt == STARVE_LIMIT).
REQ-024 Grant: if w_valid_i && !w_stall_o, pipeline owns the port; else if hv, H owns the port and hv clears next cycle; else idle.
REQ-025 rf_rd_o/rf_value_o SHALL present the granted source's rd/value (H fields when idle); rf_store_o=1 only when a grant exists and its rd != 0.
REQ-026 Grant with rd == 0 SHALL still consume the request (H drains) without asserting rf_store_o.
REQ-027 starve_cnt SHALL increment when hv && pipeline granted, reset to 0 when H drains or hv=0; never exceeds STARVE_LIMIT.
REQ-028 Under w_stall_o the pipeline write SHALL NOT occur; H drains that cycle; w_stall_o drops the next cycle.
REQ-029 m_issue_i with m_issue_rd_i != 0 SHALL set pending[m_issue_rd_i] next cycle; H drain SHALL clear pending[hrd].
REQ-030 Simultaneous set and clear of the same pending bit: set SHALL win.
REQ-031 d_stall_o SHALL be d_valid_i && (pending[d_rs1_i] || pending[d_rs2_i] || pending[d_rd_i]), each term masked when the index is 0; uses registered pending only (bit clearing this cycle still stalls).
REQ-032 busy_o SHALL equal hv || (|pending).
REQ-033 Same-cycle m_valid_i and H drain: m_ready_o is 0 (hv=1), so no new result is accepted that cycle; acceptance occurs the following cycle.

Reset
REQ-034 While rst_n_i=0 at a clock edge: hv=0, pending=0, starve_cnt=0.
REQ-035 While rst_n_i=0: rf_store_o=0, w_stall_o=0, d_stall_o=0 (gated); after reset: m_ready_o=1, busy_o=0.
REQ-036 Reset asserted mid-operation SHALL discard the held result and all pending bits without a register file write.

Verification
REQ-037 Idle, w_valid_i=1 rd=5 val=0x11 -> same cycle rf_store_o=1, rf_rd_o=5, rf_value_o=0x11; w_stall_o=0.
REQ-038 m_issue rd=7; decode rs1=7 -> d_stall_o=1 until the cycle after H(rd=7,0xABCD) drains; drain with no W traffic -> rf write 7/0xABCD, pending[7]=0 next cycle.
REQ-039 H held, w_valid_i=1 every cycle, STARVE_LIMIT=4 -> 4 pipeline writes, 5th cycle w_stall_o=1 and H written, 6th cycle w_stall_o=0.
REQ-040 Result with rd=0 -> H drains, rf_store_o stays 0, m_ready_o returns to 1 next cycle.
REQ-041 Drain of rd=3 coincides with new m_issue rd=3 -> pending[3]=1 afterwards; decode d_rd_i=3 stalls.
REQ-042 rst_n_i=0 one cycle with hv=1 and pending[9]=1 -> hv=0, pending=0, busy_o=0, no rf write issued.
